// File: rtl/register_file_1w_multi_port_read_init.sv
// rtl/register_file_1w_multi_port_read_init.sv - 1W/N-read SCM with ratio-sliced registered reads and zeroing init sequencer
// Optional per-byte write enables: define SCM_WRITE_BE_EN.
module register_file_1w_multi_port_read_init #(
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 128,
  parameter int RDATA_WIDTH = 32,
  parameter int N_READ = 4,
  localparam int RATIO = WDATA_WIDTH / RDATA_WIDTH,
  localparam int LOG_RATIO = $clog2(RATIO),
  localparam int RADDR_WIDTH = WADDR_WIDTH + LOG_RATIO
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_READ-1:0]             ReadEnable,
  input  logic [N_READ*RADDR_WIDTH-1:0] ReadAddr,
  output logic [N_READ*RDATA_WIDTH-1:0] ReadData,
  output logic [N_READ-1:0]             ReadValid,
  input  logic                          WriteEnable,
  output logic                          WriteGnt,
  input  logic [WADDR_WIDTH-1:0]        WriteAddr,
  input  logic [WDATA_WIDTH-1:0]        WriteData,
`ifdef SCM_WRITE_BE_EN
  input  logic [WDATA_WIDTH/8-1:0]      WriteBE,
`endif
  output logic                          InitBusy
);
  localparam int NUM_W_WORDS = 2**WADDR_WIDTH;
  localparam int NUM_BYTES = WDATA_WIDTH / 8;
  localparam int SEL_W = (LOG_RATIO > 0) ? LOG_RATIO : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state, state_next;
  logic [WADDR_WIDTH-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    InitBusy   = 1'b0;
    WriteGnt   = 1'b0;
    case (state)
      INIT: begin
        InitBusy = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == WADDR_WIDTH'(NUM_W_WORDS - 1)) state_next = RUN;
      end
      RUN:     WriteGnt = 1'b1;
      default: state_next = INIT;
    endcase
  end

  logic                   wr_accept;
  logic                   wr_q;
  logic                   wr_clk_en;
  logic [NUM_W_WORDS-1:0] wsel_q;
  logic [WDATA_WIDTH-1:0] wdata_q;
  logic [NUM_BYTES-1:0]   byte_en;

  assign wr_accept = WriteEnable && WriteGnt;

  // Init reuses the normal write path: stage 1 loads a zero word at cnt.
  always_ff @(posedge clk) begin
    if (rst) wr_q <= 1'b0;
    else     wr_q <= wr_accept || InitBusy;
    if (InitBusy) begin
      wsel_q  <= NUM_W_WORDS'(1) << cnt;
      wdata_q <= '0;
    end else if (wr_accept) begin
      wsel_q  <= NUM_W_WORDS'(1) << WriteAddr;
      wdata_q <= WriteData;
    end
  end

`ifdef SCM_WRITE_BE_EN
  logic [NUM_BYTES-1:0] wbe_q;

  always_ff @(posedge clk) begin
    if (InitBusy)       wbe_q <= '1;
    else if (wr_accept) wbe_q <= WriteBE;
  end

  assign byte_en = wbe_q;
`else
  assign byte_en = '1;
`endif

  // A reset arriving while stage 1 is loaded keeps the gate closed, discarding that write.
  assign wr_clk_en = wr_q && !rst;

  logic [NUM_BYTES-1:0][7:0] mem [NUM_W_WORDS];

  // Low-phase update models the gated latch window, so a same-edge read sees the new word.
  always_ff @(negedge clk) begin
    for (int w = 0; w < NUM_W_WORDS; w++) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_clk_en && wsel_q[w] && byte_en[b]) mem[w][b] <= wdata_q[b*8 +: 8];
      end
    end
  end

  for (genvar z = 0; z < N_READ; z++) begin : g_rd
    logic                              ren_q;
    logic [RADDR_WIDTH-1:0]            raddr_q;
    logic [WADDR_WIDTH-1:0]            rword;
    logic [SEL_W-1:0]                  rslice;
    logic [RATIO-1:0][RDATA_WIDTH-1:0] word_data;
    logic [RDATA_WIDTH-1:0]            rdata_q;
    logic                              rvalid_q;

    assign rword     = raddr_q[RADDR_WIDTH-1 -: WADDR_WIDTH];
    assign word_data = mem[rword];

    if (LOG_RATIO > 0) begin : g_sel
      assign rslice = raddr_q[SEL_W-1:0];
    end else begin : g_nosel
      assign rslice = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ren_q    <= 1'b0;
        raddr_q  <= '0;
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        ren_q <= ReadEnable[z] && !InitBusy;
        if (ReadEnable[z] && !InitBusy) raddr_q <= ReadAddr[z*RADDR_WIDTH +: RADDR_WIDTH];
        rvalid_q <= ren_q;
        if (ren_q) rdata_q <= word_data[rslice];
      end
    end

    assign ReadData[z*RDATA_WIDTH +: RDATA_WIDTH] = rdata_q;
    assign ReadValid[z] = rvalid_q;
  end

endmodule
